ex_mem_stage: RTL and testbench

Pipeline register and flag unit between the execute stage (ALU, including the packed saturating nibble adder) and the memory stage of the 16-bit 5-stage processor. It captures each executed instruction's result and control bits, updates the Z/V/N flag register per opcode, and applies stall and flush. After a halt is captured, it latches a sticky halt state and stops admitting instructions.

---
 rtl/ex_mem_stage.sv | 167 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline register and Z/V/N flag unit for the 16-bit 5-stage core.
//   Captures each executed instruction's result and control bits, updates the
//   architectural flags per opcode, applies stall/flush, and latches a sticky
//   halt once an HLT has been admitted.
//
//   Optional feature macro: SAT_FLAG_EN
//     defined   -> an admitted PADDSB sets V = |ex_sat (Z, N hold)
//     undefined -> ex_sat is ignored and PADDSB leaves all flags unchanged
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 hold every register, flag and halted this cycle
//   flush                 squash the incoming EX instruction (bubble)
//   ex_valid..ex_halt     EX-stage instruction payload and control
//   mem_valid..mem_halt   registered payload/control presented to MEM
//   mem_store_data        registered store data
//   flag_z/flag_v/flag_n  architectural flags
//   halted                sticky halt, cleared only by reset
// ---------------------------------------------------------------------------
module ex_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        ex_valid,
   input  logic [3:0]  ex_opcode,
   input  logic [15:0] ex_result,
   input  logic        ex_ovf,
   input  logic [3:0]  ex_sat,
   input  logic [3:0]  ex_rd,
   input  logic        ex_wr_en,
   input  logic        ex_mem_rd,
   input  logic        ex_mem_wr,
   input  logic [15:0] ex_store_data,
   input  logic        ex_halt,
   output logic        mem_valid,
   output logic [15:0] mem_result,
   output logic [3:0]  mem_rd,
   output logic        mem_wr_en,
   output logic        mem_mem_rd,
   output logic        mem_mem_wr,
   output logic        mem_halt,
   output logic [15:0] mem_store_data,
   output logic        flag_z,
   output logic        flag_v,
   output logic        flag_n,
   output logic        halted
);

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_XOR    = 4'h2,
      OP_RED    = 4'h3,
      OP_SLL    = 4'h4,
      OP_SRA    = 4'h5,
      OP_ROR    = 4'h6,
      OP_PADDSB = 4'h7
   } opcode_e;

   logic        r_valid;
   logic [15:0] r_result;
   logic [3:0]  r_rd;
   logic        r_wr_en;
   logic        r_mem_rd;
   logic        r_mem_wr;
   logic        r_halt;
   logic [15:0] r_store_data;
   logic        r_z;
   logic        r_v;
   logic        r_n;
   logic        r_halted;

   logic        w_admit;
   logic        w_z_nxt;
   logic        w_v_nxt;
   logic        w_n_nxt;

`ifndef SAT_FLAG_EN
   // ex_sat stays on the port list so EX wiring is identical in both builds.
   logic        w_unused_sat;
   assign w_unused_sat = ^ex_sat;
`endif

   always_comb begin
      w_admit = ex_valid & ~flush & ~r_halted;
      w_z_nxt = r_z;
      w_v_nxt = r_v;
      w_n_nxt = r_n;
      // Flags are state, not payload: only an admitted instruction moves them.
      if (w_admit) begin
         case (ex_opcode)
            OP_ADD, OP_SUB: begin
               w_z_nxt = (ex_result == '0);
               w_n_nxt = ex_result[15];
               w_v_nxt = ex_ovf;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
               w_z_nxt = (ex_result == '0);
            end
`ifdef SAT_FLAG_EN
            OP_PADDSB: begin
               w_v_nxt = |ex_sat;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_result     <= '0;
         r_rd         <= '0;
         r_wr_en      <= 1'b0;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_halt       <= 1'b0;
         r_store_data <= '0;
         r_z          <= 1'b0;
         r_v          <= 1'b0;
         r_n          <= 1'b0;
         r_halted     <= 1'b0;
      end else if (!stall) begin
         if (w_admit) begin
            r_valid      <= 1'b1;
            r_result     <= ex_result;
            r_rd         <= ex_rd;
            r_wr_en      <= ex_wr_en;
            r_mem_rd     <= ex_mem_rd;
            r_mem_wr     <= ex_mem_wr;
            r_halt       <= ex_halt;
            r_store_data <= ex_store_data;
         end else begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_rd         <= '0;
            r_wr_en      <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_halt       <= 1'b0;
            r_store_data <= '0;
         end
         r_z      <= w_z_nxt;
         r_v      <= w_v_nxt;
         r_n      <= w_n_nxt;
         r_halted <= r_halted | (w_admit & ex_halt);
      end
   end

   assign mem_valid      = r_valid;
   assign mem_result     = r_result;
   assign mem_rd         = r_rd;
   assign mem_wr_en      = r_wr_en;
   assign mem_mem_rd     = r_mem_rd;
   assign mem_mem_wr     = r_mem_wr;
   assign mem_halt       = r_halt;
   assign mem_store_data = r_store_data;
   assign flag_z         = r_z;
   assign flag_v         = r_v;
   assign flag_n         = r_n;
   assign halted         = r_halted;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Self-checking bench for ex_mem_stage: directed scenarios with literal
//   expectations, then randomized traffic checked every cycle against a
//   behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        ex_valid = 1'b0;
   logic [3:0]  ex_opcode = '0;
   logic [15:0] ex_result = '0;
   logic        ex_ovf = 1'b0;
   logic [3:0]  ex_sat = '0;
   logic [3:0]  ex_rd = '0;
   logic        ex_wr_en = 1'b0;
   logic        ex_mem_rd = 1'b0;
   logic        ex_mem_wr = 1'b0;
   logic [15:0] ex_store_data = '0;
   logic        ex_halt = 1'b0;

   logic        mem_valid;
   logic [15:0] mem_result;
   logic [3:0]  mem_rd;
   logic        mem_wr_en;
   logic        mem_mem_rd;
   logic        mem_mem_wr;
   logic        mem_halt;
   logic [15:0] mem_store_data;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;
   logic        halted;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
      .ex_ovf(ex_ovf), .ex_sat(ex_sat), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_store_data(ex_store_data), .ex_halt(ex_halt),
      .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
      .mem_wr_en(mem_wr_en), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
      .mem_halt(mem_halt), .mem_store_data(mem_store_data),
      .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .halted(halted)
   );

   always #5 clk = ~clk;

   // Observable state of the stage, as the model sees it.
   typedef struct packed {
      logic        valid;
      logic [15:0] result;
      logic [3:0]  rd;
      logic        wr;
      logic        mrd;
      logic        mwr;
      logic        halt;
      logic [15:0] sd;
      logic        z;
      logic        v;
      logic        n;
      logic        halted;
   } st_t;

   st_t m;
   st_t d;
   assign d = {mem_valid, mem_result, mem_rd, mem_wr_en, mem_mem_rd,
               mem_mem_wr, mem_halt, mem_store_data, flag_z, flag_v,
               flag_n, halted};

`ifdef SAT_FLAG_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   function automatic st_t model_next(st_t s);
      st_t t;
      bit  admit;
      t = s;
      if (stall) return t;
      admit = ex_valid && !flush && !s.halted;
      if (!admit) begin
         t.valid = 0; t.result = 0; t.rd = 0; t.wr = 0; t.mrd = 0;
         t.mwr = 0; t.halt = 0; t.sd = 0;
         return t;
      end
      t.valid = 1; t.result = ex_result; t.rd = ex_rd; t.wr = ex_wr_en;
      t.mrd = ex_mem_rd; t.mwr = ex_mem_wr; t.halt = ex_halt;
      t.sd = ex_store_data;
      if (ex_opcode <= 4'd1) begin
         t.z = (ex_result == 16'd0);
         t.n = (ex_result >= 16'h8000);
         t.v = ex_ovf;
      end else if (ex_opcode == 4'd2 || ex_opcode == 4'd4 ||
                   ex_opcode == 4'd5 || ex_opcode == 4'd6) begin
         t.z = (ex_result == 16'd0);
      end else if (ex_opcode == 4'd7 && SAT_EN) begin
         t.v = (ex_sat != 4'd0);
      end
      if (ex_halt) t.halted = 1;
      return t;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_next(m);
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic cmp_model();
      n_tests++;
      if (d !== m) begin
         n_fail++;
         $display("FAIL model_cmp cyc=%0d got=%h expected=%h", cyc, d, m);
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                        input logic ovf, input logic [3:0] sat, input logic hlt);
      ex_valid = v; ex_opcode = op; ex_result = res; ex_ovf = ovf; ex_sat = sat;
      ex_halt = hlt; ex_rd = 4'h3; ex_wr_en = 1'b1; ex_mem_rd = 1'b0;
      ex_mem_wr = 1'b0; ex_store_data = 16'h5A5A;
   endtask

   // One capture edge, then compare away from it.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      cmp_model();
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      cmp_model();
      chk("rst_valid", {15'd0, mem_valid}, 16'd0);
      chk("rst_flags", {12'd0, flag_z, flag_v, flag_n, halted}, 16'd0);
      rst_n = 1'b1;

      // ADD -> 0
      drive(1, 4'h0, 16'h0000, 0, 4'h0, 0); step();
      chk("add0_valid", {15'd0, mem_valid}, 16'd1);
      chk("add0_result", mem_result, 16'h0000);
      chk("add0_znv", {13'd0, flag_z, flag_n, flag_v}, 16'b100);
      // SUB 0x8000 ovf
      drive(1, 4'h1, 16'h8000, 1, 4'h0, 0); step();
      chk("sub_znv", {13'd0, flag_z, flag_n, flag_v}, 16'b011);
      // XOR 0x0001: N, V hold
      drive(1, 4'h2, 16'h0001, 0, 4'h0, 0); step();
      chk("xor_znv", {13'd0, flag_z, flag_n, flag_v}, 16'b011);
      // ADD 0x0001 clears V so the PADDSB effect is visible
      drive(1, 4'h0, 16'h0001, 0, 4'h0, 0); step();
      chk("add1_znv", {13'd0, flag_z, flag_n, flag_v}, 16'b000);
      drive(1, 4'h7, 16'h7F80, 0, 4'b0110, 0); step();
      chk("paddsb_result", mem_result, 16'h7F80);
      chk("paddsb_v", {15'd0, flag_v}, {15'd0, SAT_EN});

      // ADD 0x1234 then 3 stalled cycles with flush asserted
      drive(1, 4'h0, 16'h1234, 0, 4'h0, 0); step();
      stall = 1'b1; flush = 1'b1;
      drive(1, 4'h1, 16'h0000, 1, 4'h0, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_result", mem_result, 16'h1234);
         chk("stall_valid", {15'd0, mem_valid}, 16'd1);
      end
      stall = 1'b0; step();
      chk("flush_bubble", {14'd0, mem_valid, mem_wr_en}, 16'd0);
      chk("flush_flags", {12'd0, flag_z, flag_n, flag_v, halted}, 16'd0);

      // HLT together with flush is squashed
      drive(1, 4'hF, 16'h00AA, 0, 4'h0, 1); step();
      chk("hlt_flushed", {14'd0, mem_halt, halted}, 16'd0);
      flush = 1'b0;
      // Admitted HLT, then an ADD -> 0 becomes a bubble
      step();
      chk("hlt_taken", {13'd0, mem_valid, mem_halt, halted}, 16'b111);
      drive(1, 4'h0, 16'h0000, 0, 4'h0, 0); step();
      chk("post_hlt", {12'd0, mem_valid, mem_halt, flag_z, halted}, 16'b0001);
      // Asynchronous reset while halted, no clock edge
      #2 rst_n = 1'b0;
      #1 chk("async_rst_halted", {15'd0, halted}, 16'd0);
      cmp_model();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         ex_valid      = ($urandom_range(0, 7) != 0);
         ex_opcode     = 4'($urandom);
         ex_result     = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
         ex_ovf        = 1'($urandom);
         ex_sat        = 4'($urandom);
         ex_rd         = 4'($urandom);
         ex_wr_en      = 1'($urandom);
         ex_mem_rd     = 1'($urandom);
         ex_mem_wr     = 1'($urandom);
         ex_store_data = 16'($urandom);
         ex_halt       = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            #1 cmp_model();
            @(negedge clk);
            rst_n = 1'b1;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
